fifo_word_packer: RTL

//  Read-side consumer of the async FIFO, running in the FIFO read clock domain.

---
 rtl/fifo_word_packer_pkg.sv | 11 +
 rtl/fifo_packer_timer.sv | 19 +
 rtl/fifo_word_packer.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_word_packer_pkg.sv
// fifo_word_packer_pkg: packer state encodings, default geometry and error-counter width
package fifo_word_packer_pkg;
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LANES   = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int ERR_CNT_W   = 8;
endpackage

// File: rtl/fifo_packer_timer.sv
// fifo_packer_timer: idle counter that pulses flush_o on the TIMEOUT-th consecutive idle cycle
module fifo_packer_timer
  import fifo_word_packer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  output logic flush_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  assign cnt_d   = inc_i ? cnt_q + 1'b1 : '0;
  assign flush_o = inc_i && cnt_q == TW'(TIMEOUT - 1);
  // idle counter; any non-idle cycle (a read, an empty word, or HOLD) restarts it
  always_ff @(posedge clk_i)
    cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains FIFO entries into LANES-wide words on a valid/ready port; PACKER_TIMEOUT_EN flushes partial words
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LANES   = DEF_LANES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   rd_en_o,
  input  logic [WIDTH-1:0]       rdata_i,
  input  logic                   empty_i,
  input  logic                   error_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [WIDTH*LANES-1:0] m_data_o,
  output logic [LANES-1:0]       m_keep_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);
  localparam int LW = $clog2(LANES) + 1;
  state_e                 state_q, state_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic                   pend_q;
  logic [WIDTH*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]       keep_q, keep_d;
  logic                   valid_q, valid_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic                   flush;
  assign rd_en_o = !rst_i && !empty_i && state_q == FILL &&
                   (lane_q + {{(LW-1){1'b0}}, pend_q}) < LW'(LANES);
`ifdef PACKER_TIMEOUT_EN
  fifo_packer_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (state_q == FILL && lane_q != '0 && !pend_q && empty_i),
    .flush_o (flush)
  );
`else
  assign flush = TIMEOUT < 0;
`endif
  assign err_d     = (error_i && err_q != '1) ? err_q + 1'b1 : err_q;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign err_cnt_o = err_q;
  // capture returning entries into the next free lane, present the word, clear it on acceptance
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    if (state_q == HOLD) begin
      if (m_ready_i) begin
        state_d = FILL;
        lane_d  = '0;
        data_d  = '0;
        keep_d  = '0;
        valid_d = 1'b0;
      end
    end else begin
      if (pend_q) begin
        for (int l = 0; l < LANES; l++)
          if (lane_q == LW'(l)) begin
            data_d[l*WIDTH +: WIDTH] = rdata_i;
            keep_d[l]                = 1'b1;
          end
        lane_d = lane_q + 1'b1;
      end
      if ((pend_q && lane_q == LW'(LANES - 1)) || flush) begin
        state_d = HOLD;
        valid_d = 1'b1;
      end
    end
  end
  // state, lane storage, read pipeline flag and saturating error count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      lane_q  <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      pend_q  <= rd_en_o;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
endmodule
